// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   MEM stage of the MIPS pipeline, directly downstream of EX. Performs word
//   loads/stores on an internal synchronous data memory and registers the
//   MEM/WB record (write-back data, destination register, regwrite).
//   After every reset a clear sweep zeroes the whole data memory, one word
//   per cycle, before any instruction is accepted.
//
// Ports
//   ms_clk          in   1       clock, rising edge
//   ms_rst          in   1       asynchronous active-low reset
//   ms_i_ce         in   1       valid instruction from EX
//   ms_i_stall      in   1       hold outputs and memory
//   ms_i_alu_value  in   DWIDTH  byte address or R-type result
//   ms_i_data_rt    in   DWIDTH  store data
//   ms_i_memread    in   1       load
//   ms_i_memwrite   in   1       store
//   ms_i_memtoreg   in   1       write-back data from memory (1) or ALU (0)
//   ms_i_regwrite   in   1       instruction writes rd
//   ms_i_rd_addr    in   AWIDTH  destination register
//   ms_o_wb_data    out  DWIDTH  registered write-back data
//   ms_o_rd_addr    out  AWIDTH  registered destination register
//   ms_o_regwrite   out  1       registered regwrite, suppressed on fault
//   ms_o_ce         out  1       MEM/WB record valid
//   ms_o_fault      out  1       access misaligned or out of range
//   ms_o_busy       out  1       clear sweep in progress
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 6
) (
    input  logic              ms_clk,
    input  logic              ms_rst,
    input  logic              ms_i_ce,
    input  logic              ms_i_stall,
    input  logic [DWIDTH-1:0] ms_i_alu_value,
    input  logic [DWIDTH-1:0] ms_i_data_rt,
    input  logic              ms_i_memread,
    input  logic              ms_i_memwrite,
    input  logic              ms_i_memtoreg,
    input  logic              ms_i_regwrite,
    input  logic [AWIDTH-1:0] ms_i_rd_addr,
    output logic [DWIDTH-1:0] ms_o_wb_data,
    output logic [AWIDTH-1:0] ms_o_rd_addr,
    output logic              ms_o_regwrite,
    output logic              ms_o_ce,
    output logic              ms_o_fault,
    output logic              ms_o_busy
);

    localparam int               WORDS    = 2 ** DEPTH;
    localparam logic [DEPTH-1:0] IDX_LAST = '1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DEPTH-1:0]  r_clr_idx;
    logic [DWIDTH-1:0] r_mem [WORDS];

    logic [DWIDTH-1:0] r_wb_data;
    logic [AWIDTH-1:0] r_rd_addr;
    logic              r_regwrite;
    logic              r_ce;
    logic              r_fault;

    logic              w_busy;
    logic              w_clr_we;
    logic [DEPTH-1:0]  w_idx;
    logic              w_bad;
    logic              w_fault;
    logic              w_accept;
    logic              w_store;
    logic              w_load;
    logic              w_both;
    logic [DWIDTH-1:0] w_mem_rdata;
    logic [DWIDTH-1:0] w_wb_next;
    logic              w_regwrite_next;
    logic              w_mem_we;
    logic [DEPTH-1:0]  w_mem_waddr;
    logic [DWIDTH-1:0] w_mem_wdata;

    // Address decode: word index plus the "bad address" test. Anything with
    // low bits set is misaligned; anything above the memory is out of range.
    assign w_idx   = ms_i_alu_value[DEPTH+1:2];
    assign w_bad   = (ms_i_alu_value[1:0] != 2'b00) ||
                     (ms_i_alu_value[DWIDTH-1:DEPTH+2] != '0);
    assign w_fault = (ms_i_memread || ms_i_memwrite) && w_bad;

    // An instruction is only taken in RUN with no stall.
    assign w_accept = (r_state == S_RUN) && !ms_i_stall && ms_i_ce;
    assign w_store  = w_accept && ms_i_memwrite && !w_fault;

    // memread together with memwrite behaves as a pure store: no read and
    // no register write.
    assign w_both = ms_i_memread && ms_i_memwrite;
    assign w_load = ms_i_memread && !ms_i_memwrite && ms_i_memtoreg;

    // The memory is read combinationally into the pipeline register, so a
    // store landing on the previous edge is already visible to a load.
    assign w_mem_rdata     = r_mem[w_idx];
    assign w_wb_next       = w_load ? (w_fault ? '0 : w_mem_rdata) : ms_i_alu_value;
    assign w_regwrite_next = ms_i_regwrite && !w_fault && !w_both;

    // Single write port shared by the clear sweep and normal stores; the
    // sweep owns it whenever the FSM is in CLEAR.
    assign w_mem_we    = w_clr_we || w_store;
    assign w_mem_waddr = w_clr_we ? r_clr_idx : w_idx;
    assign w_mem_wdata = w_clr_we ? '0 : ms_i_data_rt;

    // FSM state register and clear index. Reset always restarts the sweep
    // from word 0.
    always_ff @(posedge ms_clk or negedge ms_rst) begin
        if (!ms_rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clr_we) begin
                r_clr_idx <= r_clr_idx + DEPTH'(1);
            end
        end
    end

    // FSM next-state and outputs: CLEAR writes one zero word per cycle and
    // leaves for RUN on the edge that writes the last word.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_clr_we     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
                if (r_clr_idx == IDX_LAST) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase
    end

    // Data memory array. Not reset: the clear sweep provides the zeroes.
    always_ff @(posedge ms_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // MEM/WB record. Stall freezes everything; a bubble clears the valid
    // flags but keeps the data/register fields.
    always_ff @(posedge ms_clk or negedge ms_rst) begin
        if (!ms_rst) begin
            r_wb_data  <= '0;
            r_rd_addr  <= '0;
            r_regwrite <= 1'b0;
            r_ce       <= 1'b0;
            r_fault    <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_regwrite <= 1'b0;
            r_ce       <= 1'b0;
            r_fault    <= 1'b0;
        end else if (!ms_i_stall) begin
            if (ms_i_ce) begin
                r_wb_data  <= w_wb_next;
                r_rd_addr  <= ms_i_rd_addr;
                r_regwrite <= w_regwrite_next;
                r_ce       <= 1'b1;
                r_fault    <= w_fault;
            end else begin
                r_regwrite <= 1'b0;
                r_ce       <= 1'b0;
                r_fault    <= 1'b0;
            end
        end
    end

    assign ms_o_wb_data  = r_wb_data;
    assign ms_o_rd_addr  = r_rd_addr;
    assign ms_o_regwrite = r_regwrite;
    assign ms_o_ce       = r_ce;
    assign ms_o_fault    = r_fault;
    assign ms_o_busy     = w_busy;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//   Self-checking bench for memory_stage. A behavioural model (word array,
//   sweep countdown, expected MEM/WB record) is compared against the DUT on
//   every clock while reset is released; directed scenarios add literal
//   expectations computed by hand.
// ---------------------------------------------------------------------------
module tb_memory_stage;

    localparam int WORDS = 64;

    logic        ms_clk = 1'b0;
    logic        ms_rst;
    logic        ms_i_ce;
    logic        ms_i_stall;
    logic [31:0] ms_i_alu_value;
    logic [31:0] ms_i_data_rt;
    logic        ms_i_memread;
    logic        ms_i_memwrite;
    logic        ms_i_memtoreg;
    logic        ms_i_regwrite;
    logic [4:0]  ms_i_rd_addr;
    logic [31:0] ms_o_wb_data;
    logic [4:0]  ms_o_rd_addr;
    logic        ms_o_regwrite;
    logic        ms_o_ce;
    logic        ms_o_fault;
    logic        ms_o_busy;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state.
    logic [31:0] mMem [WORDS];
    int          clearLeft;
    logic [31:0] expWb;
    logic [4:0]  expRd;
    logic        expRw;
    logic        expCe;
    logic        expFault;
    logic        expBusy;

    // 100 MHz-style free-running clock.
    always #5 ms_clk = ~ms_clk;

    memory_stage #(
        .DWIDTH(32),
        .AWIDTH(5),
        .DEPTH (6)
    ) dut (
        .ms_clk        (ms_clk),
        .ms_rst        (ms_rst),
        .ms_i_ce       (ms_i_ce),
        .ms_i_stall    (ms_i_stall),
        .ms_i_alu_value(ms_i_alu_value),
        .ms_i_data_rt  (ms_i_data_rt),
        .ms_i_memread  (ms_i_memread),
        .ms_i_memwrite (ms_i_memwrite),
        .ms_i_memtoreg (ms_i_memtoreg),
        .ms_i_regwrite (ms_i_regwrite),
        .ms_i_rd_addr  (ms_i_rd_addr),
        .ms_o_wb_data  (ms_o_wb_data),
        .ms_o_rd_addr  (ms_o_rd_addr),
        .ms_o_regwrite (ms_o_regwrite),
        .ms_o_ce       (ms_o_ce),
        .ms_o_fault    (ms_o_fault),
        .ms_o_busy     (ms_o_busy)
    );

    // A memory access is legal only for word-aligned byte addresses that
    // fall inside the 256-byte data memory.
    function automatic logic isFault(input logic [31:0] addr, input logic rd, input logic wr);
        return (rd || wr) && !((addr % 32'd4 == 32'd0) && (addr < 32'd256));
    endfunction

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr / 32'd4) % 32'd64);
    endfunction

    // Common comparison: one FAIL line per mismatch, counters always stepped.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update. Reset zeroes the abstract memory and arms a 64-cycle
    // busy countdown; afterwards each accepted instruction is evaluated from
    // its address/control fields with plain arithmetic.
    always @(posedge ms_clk or negedge ms_rst) begin : model
        if (!ms_rst) begin
            clearLeft <= WORDS;
            expBusy   <= 1'b1;
            expWb     <= '0;
            expRd     <= '0;
            expRw     <= 1'b0;
            expCe     <= 1'b0;
            expFault  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mMem[i] <= '0;
            end
        end else if (clearLeft > 0) begin
            clearLeft <= clearLeft - 1;
            expBusy   <= (clearLeft > 1);
            expCe     <= 1'b0;
            expRw     <= 1'b0;
            expFault  <= 1'b0;
        end else if (!ms_i_stall && ms_i_ce) begin
            expCe    <= 1'b1;
            expRd    <= ms_i_rd_addr;
            expFault <= isFault(ms_i_alu_value, ms_i_memread, ms_i_memwrite);
            expRw    <= ms_i_regwrite && !isFault(ms_i_alu_value, ms_i_memread, ms_i_memwrite)
                        && !(ms_i_memread && ms_i_memwrite);
            if (ms_i_memwrite && !isFault(ms_i_alu_value, ms_i_memread, ms_i_memwrite)) begin
                mMem[wordOf(ms_i_alu_value)] <= ms_i_data_rt;
            end
            if (ms_i_memread && !ms_i_memwrite && ms_i_memtoreg) begin
                expWb <= isFault(ms_i_alu_value, ms_i_memread, ms_i_memwrite) ?
                         32'd0 : mMem[wordOf(ms_i_alu_value)];
            end else begin
                expWb <= ms_i_alu_value;
            end
        end else if (!ms_i_stall) begin
            expCe    <= 1'b0;
            expRw    <= 1'b0;
            expFault <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, 1 time unit after each edge,
    // whenever reset is released.
    always @(posedge ms_clk) begin : compare
        #1;
        if (ms_rst === 1'b1) begin
            checkOutput("cyc_busy",     32'(ms_o_busy),     32'(expBusy));
            checkOutput("cyc_ce",       32'(ms_o_ce),       32'(expCe));
            checkOutput("cyc_regwrite", 32'(ms_o_regwrite), 32'(expRw));
            checkOutput("cyc_fault",    32'(ms_o_fault),    32'(expFault));
            checkOutput("cyc_rd_addr",  32'(ms_o_rd_addr),  32'(expRd));
            checkOutput("cyc_wb_data",  ms_o_wb_data,       expWb);
        end
    end

    // Drive one input vector on the falling edge; the next rising edge
    // samples it.
    task automatic applyStimulus(input logic ce, input logic stall,
                                 input logic [31:0] alu, input logic [31:0] rt,
                                 input logic mr, input logic mw, input logic mtr,
                                 input logic rw, input logic [4:0] rd);
        @(negedge ms_clk);
        ms_i_ce        = ce;
        ms_i_stall     = stall;
        ms_i_alu_value = alu;
        ms_i_data_rt   = rt;
        ms_i_memread   = mr;
        ms_i_memwrite  = mw;
        ms_i_memtoreg  = mtr;
        ms_i_regwrite  = rw;
        ms_i_rd_addr   = rd;
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [4:0] rd);
        applyStimulus(1'b1, 1'b0, addr, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, rd);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic waitEdge();
        @(posedge ms_clk);
        #2;
    endtask

    // Count rising edges until busy drops, bounded so a stuck sweep still
    // reaches the summary.
    task automatic countBusy(output int cycles);
        cycles = 0;
        do begin
            @(posedge ms_clk);
            #2;
            cycles++;
        end while (ms_o_busy && cycles < 200);
    endtask

    // Directed scenario sequence.
    initial begin : stimulus
        int busyCycles;
        ms_rst         = 1'b0;
        ms_i_ce        = 1'b0;
        ms_i_stall     = 1'b0;
        ms_i_alu_value = '0;
        ms_i_data_rt   = '0;
        ms_i_memread   = 1'b0;
        ms_i_memwrite  = 1'b0;
        ms_i_memtoreg  = 1'b0;
        ms_i_regwrite  = 1'b0;
        ms_i_rd_addr   = '0;

        // Reset state.
        waitEdge();
        checkOutput("rst_busy",     32'(ms_o_busy),     32'd1);
        checkOutput("rst_ce",       32'(ms_o_ce),       32'd0);
        checkOutput("rst_regwrite", 32'(ms_o_regwrite), 32'd0);
        checkOutput("rst_fault",    32'(ms_o_fault),    32'd0);
        checkOutput("rst_wb_data",  ms_o_wb_data,       32'd0);
        checkOutput("rst_rd_addr",  32'(ms_o_rd_addr),  32'd0);

        // 1: clear sweep length, then every word reads back zero.
        @(negedge ms_clk);
        ms_rst = 1'b1;
        countBusy(busyCycles);
        checkOutput("t1_busy_cycles", 32'(busyCycles), 32'd64);
        for (int i = 0; i < WORDS; i++) begin
            doLoad(32'(i * 4), 5'(i));
        end
        waitEdge();
        checkOutput("t1_last_load", ms_o_wb_data, 32'd0);
        checkOutput("t1_last_rd",   32'(ms_o_rd_addr), 32'd31);

        // 2: store then load the same word on the next cycle.
        doStore(32'h10, 32'hDEADBEEF);
        doLoad(32'h10, 5'd5);
        waitEdge();
        checkOutput("t2_wb_data",  ms_o_wb_data,       32'hDEADBEEF);
        checkOutput("t2_rd_addr",  32'(ms_o_rd_addr),  32'd5);
        checkOutput("t2_regwrite", 32'(ms_o_regwrite), 32'd1);
        checkOutput("t2_ce",       32'(ms_o_ce),       32'd1);

        // 3: R-type pass-through, then a bubble holds wb_data.
        applyStimulus(1'b1, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        waitEdge();
        checkOutput("t3_wb_data", ms_o_wb_data, 32'h1234);
        doIdle();
        waitEdge();
        checkOutput("t3_bubble_ce",       32'(ms_o_ce),       32'd0);
        checkOutput("t3_bubble_regwrite", 32'(ms_o_regwrite), 32'd0);
        checkOutput("t3_bubble_wb_data",  ms_o_wb_data,       32'h1234);

        // 4: faults never touch memory; 0x100 would alias word 0.
        doStore(32'h00, 32'h0000A5A5);
        doLoad(32'h13, 5'd3);
        waitEdge();
        checkOutput("t4_mis_fault",    32'(ms_o_fault),    32'd1);
        checkOutput("t4_mis_regwrite", 32'(ms_o_regwrite), 32'd0);
        checkOutput("t4_mis_wb_data",  ms_o_wb_data,       32'd0);
        doStore(32'h100, 32'h0BADBAD0);
        waitEdge();
        checkOutput("t4_oor_fault", 32'(ms_o_fault), 32'd1);
        doLoad(32'h00, 5'd2);
        waitEdge();
        checkOutput("t4_word0", ms_o_wb_data, 32'h0000A5A5);

        // memread with memwrite acts as a store only.
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h99, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6);
        waitEdge();
        checkOutput("rw_both_wb_data",  ms_o_wb_data,       32'h30);
        checkOutput("rw_both_regwrite", 32'(ms_o_regwrite), 32'd0);
        doLoad(32'h30, 5'd6);
        waitEdge();
        checkOutput("rw_both_readback", ms_o_wb_data, 32'h99);

        // 5: stall freezes outputs and blocks a store.
        doStore(32'h20, 32'h11111111);
        applyStimulus(1'b1, 1'b0, 32'h77, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h40, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
            waitEdge();
            checkOutput("t5_stall_wb_data", ms_o_wb_data,      32'h77);
            checkOutput("t5_stall_rd_addr", 32'(ms_o_rd_addr), 32'd9);
        end
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        waitEdge();
        checkOutput("t5_stall_ce", 32'(ms_o_ce), 32'd1);
        doLoad(32'h20, 5'd8);
        waitEdge();
        checkOutput("t5_mem8_unchanged", ms_o_wb_data, 32'h11111111);
        doStore(32'h20, 32'h22222222);
        doLoad(32'h20, 5'd8);
        waitEdge();
        checkOutput("t5_mem8_updated", ms_o_wb_data, 32'h22222222);

        // 6: reset mid-stream restarts the sweep and loses contents.
        doStore(32'h04, 32'h55);
        applyStimulus(1'b1, 1'b0, 32'hABC, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        doIdle();
        @(negedge ms_clk);
        #2;
        ms_rst = 1'b0;
        #1;
        checkOutput("t6_async_busy",    32'(ms_o_busy), 32'd1);
        checkOutput("t6_async_wb_data", ms_o_wb_data,   32'd0);
        checkOutput("t6_async_rd_addr", 32'(ms_o_rd_addr), 32'd0);
        @(posedge ms_clk);
        @(negedge ms_clk);
        ms_rst = 1'b1;
        countBusy(busyCycles);
        checkOutput("t6_busy_cycles", 32'(busyCycles), 32'd64);
        doLoad(32'h04, 5'd4);
        waitEdge();
        checkOutput("t6_word1_cleared", ms_o_wb_data, 32'd0);
        doIdle();
        waitEdge();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
